// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud constant and a
// parity helper that the transmitter will reuse.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int BAUD_19200_50M = 2604;

  // Even parity bit of up to 9 data bits; odd=1 flips the sense.
  function automatic logic par_calc(
    input logic [8:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tmr.sv
// Loadable baud down-counter; tick is high while the count sits at zero.
// Never wraps: it waits at zero until the next load.
module uart_baud_tmr #(
  parameter int BAUD_DIV = 16,
  parameter int BAUD_W   = $clog2(BAUD_DIV + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half,
  input  logic load_full,
  input  logic en,
  output logic tick
);

  logic [BAUD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_full) begin
      cnt <= BAUD_W'(BAUD_DIV - 1);
    end else if (load_half) begin
      cnt <= BAUD_W'(BAUD_DIV / 2);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with glitch-rejecting start, framing and
// overrun flags. Optional parity check when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = BAUD_19200_50M
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PAR_ODD   = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr_err
);

  localparam int         BAUD_W    = $clog2(BAUD_DIV + 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 frm_acc;
  logic                 fin;
  logic                 tick;
  logic                 load_half;
  logic                 load_full;
  logic                 en;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_baud_tmr #(
    .BAUD_DIV (BAUD_DIV),
    .BAUD_W   (BAUD_W)
  ) u_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_half (load_half),
    .load_full (load_full),
    .en        (en),
    .tick      (tick)
  );

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    unique case (state)
      IDLE:         load_half = !rx_s;
      START:        load_full = tick && !rx_s;
      DATA, PARITY: load_full = tick;
      STOP:         load_full = tick && !fin && (stop_cnt != LAST_STOP);
      default:      ;
    endcase
  end

  assign en = (state != IDLE);

`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      frm_acc  <= 1'b0;
      fin      <= 1'b0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;

      // Completion below overrides this clear when both land together.
      if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err <= 1'b0;
`endif
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              frm_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state    <= PARITY;
`else
              state    <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bad <= rx_s != par_calc(9'(shift), PAR_ODD);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (fin) begin
            fin     <= 1'b0;
            state   <= IDLE;
            rx_data <= shift;
            rdy     <= 1'b1;
            frm_err <= frm_acc;
            ovr_err <= !clr_rdy && (ovr_err || rdy);
`ifdef UART_RX_PARITY_EN
            par_err <= par_bad;
`endif
          end else if (tick) begin
            if (!rx_s) frm_acc <= 1'b1;
            if (stop_cnt == LAST_STOP) fin <= 1'b1;
            else stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
